guia_logic_unit_seq: RTL and testbench

Parametrised, registered successor to the two-input gate exercises: applies one of eight selectable bitwise functions to two WIDTH-bit operands, one beat per accepted transfer. Beats are grouped into frames. Over each frame the block accumulates an all-equal flag (bitwise XNOR reduced across the frame), an all-zero flag and a beat count. It sits between a valid/ready operand source and a valid/ready result sink, with a single output register.

---
 rtl/guia_logic_unit_seq_pkg.sv | 20 ++
 rtl/guia_logic_unit_seq_bitwise_fn.sv | 27 ++
 rtl/guia_logic_unit_seq.sv | 142 ++++++++++++++
 tb/tb_guia_logic_unit_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guia_logic_unit_seq_pkg.sv
// Shared types for the registered bitwise logic unit: function codes and frame FSM states.
package guia_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_e;

endpackage

// File: rtl/guia_logic_unit_seq_bitwise_fn.sv
// Combinational bitwise function selector: maps (op, a, b) to a WIDTH-bit result.
import guia_pkg::*;

module guia_bitwise_fn #(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_e'(op_i))
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_NAND: result_o = ~(a_i & b_i);
         OP_NOR:  result_o = ~(a_i | b_i);
         OP_XOR:  result_o = a_i ^ b_i;
         OP_XNOR: result_o = ~(a_i ^ b_i);
         OP_NOTA: result_o = ~a_i;
         OP_PASS: result_o = a_i;
      endcase
   end

endmodule

// File: rtl/guia_logic_unit_seq.sv
// Registered bitwise logic unit with valid/ready handshake and per-frame
// all-equal / all-zero / beat-count reporting on the closing beat.
import guia_pkg::*;

module guia_logic_unit_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_last,
   output logic             out_eq_all,
   output logic             out_zero_all,
   output logic [CNT_W-1:0] out_beats
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic             eq_acc_q, eq_acc_d;
   logic             zero_acc_q, zero_acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             out_last_q, out_last_d;
   logic             out_eq_q, out_eq_d;
   logic             out_zero_q, out_zero_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;

   logic             accept;
   logic             frame_start;
   op_e              cur_op;
   logic [WIDTH-1:0] fn_result;
   logic             eq_new, zero_new;
   logic [CNT_W-1:0] cnt_base, cnt_new;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // The first beat of a frame uses the live opcode; later beats use the latched one.
   assign frame_start = (state_q == ST_IDLE);
   assign cur_op      = frame_start ? op_e'(in_op) : op_q;

   guia_bitwise_fn #(.WIDTH(WIDTH)) u_fn (
      .op_i     (cur_op),
      .a_i      (in_a),
      .b_i      (in_b),
      .result_o (fn_result)
   );

   assign cnt_base = frame_start ? '0 : cnt_q;
   assign cnt_new  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1);
   assign eq_new   = (frame_start ? 1'b1 : eq_acc_q) & (in_a == in_b);
   assign zero_new = (frame_start ? 1'b1 : zero_acc_q) & (fn_result == '0);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      eq_acc_d     = eq_acc_q;
      zero_acc_d   = zero_acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_result_d = out_result_q;
      out_last_d   = out_last_q;
      out_eq_d     = out_eq_q;
      out_zero_d   = out_zero_q;
      out_beats_d  = out_beats_q;

      if (accept) begin
         if (frame_start) begin
            op_d = op_e'(in_op);
         end
         out_valid_d  = 1'b1;
         out_result_d = fn_result;
         out_last_d   = in_last;
         if (in_last) begin
            out_eq_d    = eq_new;
            out_zero_d  = zero_new;
            out_beats_d = cnt_new;
            state_d     = ST_IDLE;
            eq_acc_d    = 1'b1;
            zero_acc_d  = 1'b1;
            cnt_d       = '0;
         end else begin
            out_eq_d    = 1'b0;
            out_zero_d  = 1'b0;
            out_beats_d = '0;
            state_d     = ST_FRAME;
            eq_acc_d    = eq_new;
            zero_acc_d  = zero_new;
            cnt_d       = cnt_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_AND;
         eq_acc_q     <= 1'b1;
         zero_acc_q   <= 1'b1;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_last_q   <= 1'b0;
         out_eq_q     <= 1'b0;
         out_zero_q   <= 1'b0;
         out_beats_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         eq_acc_q     <= eq_acc_d;
         zero_acc_q   <= zero_acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_last_q   <= out_last_d;
         out_eq_q     <= out_eq_d;
         out_zero_q   <= out_zero_d;
         out_beats_q  <= out_beats_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_last     = out_last_q;
   assign out_eq_all   = out_eq_q;
   assign out_zero_all = out_zero_q;
   assign out_beats    = out_beats_q;

endmodule

// File: tb/tb_guia_logic_unit_seq.sv
// Bench for guia_logic_unit_seq: directed frames plus random beats against a truth-table model.
module tb_guia_logic_unit_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic [2:0] in_op = '0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, out_last, out_eq_all, out_zero_all;
   logic [7:0] out_result, out_beats;
   logic       s_in_ready, s_out_valid, s_out_last, s_out_eq_all, s_out_zero_all;
   logic [7:0] s_out_result;
   logic [1:0] s_out_beats;

   int vectors = 0;
   int miscompares = 0;

   // Frame model state
   bit      m_open = 0;
   int      m_op = 0;
   bit      m_eq = 1, m_zero = 1;
   int      m_cnt = 0;
   int      e_result, e_last, e_eq, e_zero, e_beats, e_beats_s;

   always #5 clk = ~clk;

   guia_logic_unit_seq #(.WIDTH(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_last(out_last), .out_eq_all(out_eq_all), .out_zero_all(out_zero_all),
      .out_beats(out_beats)
   );

   guia_logic_unit_seq #(.WIDTH(8), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
      .out_last(s_out_last), .out_eq_all(s_out_eq_all), .out_zero_all(s_out_zero_all),
      .out_beats(s_out_beats)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Truth table indexed by {a_bit, b_bit}
   function automatic logic [7:0] ref_fn(input int op, input logic [7:0] a, input logic [7:0] b);
      logic [3:0] tt;
      logic [7:0] r;
      case (op)
         0: tt = 4'b1000;
         1: tt = 4'b1110;
         2: tt = 4'b0111;
         3: tt = 4'b0001;
         4: tt = 4'b0110;
         5: tt = 4'b1001;
         6: tt = 4'b0011;
         default: tt = 4'b1100;
      endcase
      for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input int op, input bit last);
      int used_op;
      if (!m_open) begin
         m_op = op; m_eq = 1; m_zero = 1; m_cnt = 0;
      end
      used_op = m_op;
      e_result = int'(ref_fn(used_op, a, b));
      m_eq = m_eq && (a == b);
      m_zero = m_zero && (e_result == 0);
      m_cnt++;
      e_last = last;
      if (last) begin
         e_eq = m_eq; e_zero = m_zero;
         e_beats = (m_cnt > 255) ? 255 : m_cnt;
         e_beats_s = (m_cnt > 3) ? 3 : m_cnt;
         m_open = 0;
      end else begin
         e_eq = 0; e_zero = 0; e_beats = 0; e_beats_s = 0;
         m_open = 1;
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".result"}, out_result, e_result);
      chk({tag, ".last"}, out_last, e_last);
      chk({tag, ".eq_all"}, out_eq_all, e_eq);
      chk({tag, ".zero_all"}, out_zero_all, e_zero);
      chk({tag, ".beats"}, out_beats, e_beats);
      chk({tag, ".beats_sat"}, s_out_beats, e_beats_s);
   endtask

   // Drive one beat (leaves in_valid high for back-to-back use) and check the registered output.
   task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int op, input bit last);
      int waited = 0;
      in_valid = 1; in_a = a; in_b = b; in_op = op[2:0]; in_last = last;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         chk({tag, ".ready_timeout"}, in_ready, 1);
      end else begin
         @(posedge clk); #1;
         model_accept(a, b, op, last);
         check_out(tag);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_last = 0;
   endtask

   initial begin
      logic [7:0] ha, hb, ra, rb, r6, r7;
      int         rop;
      bit         rlast;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", out_valid, 0);
      chk("rst.result", out_result, 0);
      chk("rst.last", out_last, 0);
      chk("rst.eq", out_eq_all, 0);
      chk("rst.zero", out_zero_all, 0);
      chk("rst.beats", out_beats, 0);
      chk("rst.ready", in_ready, 1);
      rst_n = 1;

      // One-beat XNOR frame
      beat("one", 8'hA5, 8'hA5, 5, 1);
      chk("one.result_const", out_result, 8'hFF);
      chk("one.beats_const", out_beats, 1);
      idle();

      // Three beats: opcode latched from beat one
      beat("tri0", 8'hF0, 8'h0F, 0, 0);
      beat("tri1", 8'h33, 8'hCC, 1, 0);
      beat("tri2", 8'h00, 8'hFF, 1, 1);
      chk("tri.zero_const", out_zero_all, 1);
      chk("tri.beats_const", out_beats, 3);
      idle();

      // Reset mid-frame discards the partial frame
      beat("mid0", 8'h12, 8'h12, 3, 0);
      beat("mid1", 8'h34, 8'h34, 3, 0);
      idle();
      #2 rst_n = 0;
      #1;
      chk("arst.valid", out_valid, 0);
      chk("arst.result", out_result, 0);
      chk("arst.beats", out_beats, 0);
      chk("arst.ready", in_ready, 1);
      m_open = 0;
      @(posedge clk); #1 rst_n = 1;
      beat("post_rst", 8'h5A, 8'h0F, 4, 1);
      chk("post_rst.result_const", out_result, 8'h55);
      idle();

      // Backpressure: hold beat stable, then resume back-to-back
      beat("bp0", 8'hC3, 8'h3C, 1, 0);
      out_ready = 0;
      ha = $urandom; hb = $urandom;
      in_valid = 1; in_a = ha; in_b = hb; in_op = 2; in_last = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("bp.ready_low", in_ready, 0);
         @(posedge clk); #1;
         check_out("bp.hold");
      end
      out_ready = 1;
      #1 chk("bp.ready_high", in_ready, 1);
      @(posedge clk); #1;
      model_accept(ha, hb, 2, 0);
      check_out("bp.release");
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom;
         beat("b2b", ra, rb, 2, i == 3);
      end
      idle();
      @(posedge clk); #1;
      chk("drain.valid", out_valid, 0);

      // Six-beat frame: counter saturation in the narrow instance
      for (int i = 0; i < 6; i++) beat("sat", 8'h81, 8'h81, 0, i == 5);
      chk("sat.beats_s_const", s_out_beats, 3);
      chk("sat.beats_const", out_beats, 6);
      idle();

      // Ops 6 and 7 ignore in_b
      ra = $urandom;
      beat("nota0", ra, 8'h00, 6, 1); r6 = out_result;
      beat("nota1", ra, 8'hFF, 6, 1);
      chk("nota.b_indep", out_result, r6);
      beat("pass0", ra, 8'h00, 7, 1); r7 = out_result;
      beat("pass1", ra, 8'hFF, 7, 1);
      chk("pass.b_indep", out_result, r7);
      idle();

      // Every op with random operands, then random framed traffic
      for (int op = 0; op < 8; op++) begin
         for (int k = 0; k < 6; k++) begin
            ra = $urandom; rb = (k == 0) ? ra : 8'($urandom);
            beat("exh", ra, rb, op, 1);
         end
      end
      for (int k = 0; k < 150; k++) begin
         ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
         rop = $urandom_range(0, 7);
         rlast = ($urandom_range(0, 3) == 0);
         beat("rnd", ra, rb, rop, rlast);
         if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk); #1;
         end
      end
      beat("rnd_close", 8'h00, 8'h00, 0, 1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
